// File: rtl/muldiv_hilo_ctrl_if.sv
// Pipeline-facing bundle of the multiply/divide HI/LO controller.
// The EX stage (master) presents the instruction; the controller (slave)
// answers with stall/busy and the architectural HI/LO values.
`timescale 1ns/1ps
interface muldiv_hilo_ctrl_if;
    logic        en;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output en, funct, rs_val, rt_val, cancel,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  en, funct, rs_val, rt_val, cancel,
        output stall, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Multiply/divide sequencer and owner of the HI/LO registers.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; starts mult/div, performs mthi/mtlo in one edge
// MUL   | product formed from latched operands, written at exit edge
// DIV   | restoring divider, one quotient bit per cycle (cnt 0..31)
// DONE  | result visible, stall released; returns to IDLE next edge
`timescale 1ns/1ps
module muldiv_hilo_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              resetn,
    muldiv_hilo_ctrl_if.slave bus
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    // opa holds the multiplicand, or the shifting dividend/quotient during DIV
    logic [31:0] opa_q, opa_d;
    // opb holds the multiplier, or the divisor magnitude during DIV
    logic [31:0] opb_q, opb_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        req;
    logic        is_mul;
    logic        is_div;
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand decode, multiplier and one restoring-divide step
    always_comb begin
        req       = bus.en & ~bus.cancel;
        is_mul    = (bus.funct == F_MULT) | (bus.funct == F_MULTU);
        is_div    = (bus.funct == F_DIV)  | (bus.funct == F_DIVU);
        op_signed = (bus.funct == F_MULT) | (bus.funct == F_DIV);
        a_neg     = (bus.funct == F_DIV) & bus.rs_val[31];
        b_neg     = (bus.funct == F_DIV) & bus.rt_val[31];
        a_mag     = a_neg ? (~bus.rs_val + 32'd1) : bus.rs_val;
        b_mag     = b_neg ? (~bus.rt_val + 32'd1) : bus.rt_val;

        // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve both forms.
        ext_a   = {(sgn_q ? {32{opa_q[31]}} : 32'd0), opa_q};
        ext_b   = {(sgn_q ? {32{opb_q[31]}} : 32'd0), opb_q};
        product = ext_a * ext_b;

        trial   = {rem_q, opa_q[31]};
        diff    = trial - {1'b0, opb_q};
        ge      = (trial >= {1'b0, opb_q});
        rem_nxt = ge ? diff[31:0] : trial[31:0];
        quo_nxt = {opa_q[30:0], ge};
        quo_fix = negq_q ? (~quo_nxt + 32'd1) : quo_nxt;
        rem_fix = negr_q ? (~rem_nxt + 32'd1) : rem_nxt;
    end

    // Next-state, datapath updates and stall/busy
    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bus.stall = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req && is_mul) begin
                    bus.stall = 1'b1;
                    opa_d     = bus.rs_val;
                    opb_d     = bus.rt_val;
                    sgn_d     = op_signed;
                    state_d   = S_MUL;
                end else if (req && is_div) begin
                    bus.stall = 1'b1;
                    opa_d     = a_mag;
                    opb_d     = b_mag;
                    rem_d     = 32'd0;
                    cnt_d     = 5'd0;
                    sgn_d     = op_signed;
                    negq_d    = a_neg ^ b_neg;
                    negr_d    = a_neg;
                    state_d   = S_DIV;
                end else if (req && bus.funct == F_MTHI) begin
                    hi_d = bus.rs_val;
                end else if (req && bus.funct == F_MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            S_MUL: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    bus.stall = 1'b1;
                    hi_d      = product[63:32];
                    lo_d      = product[31:0];
                    state_d   = S_DONE;
                end
            end
            S_DIV: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (opb_q == 32'd0) begin
                    // Divide by zero leaves HI/LO untouched.
                    bus.stall = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    bus.stall = 1'b1;
                    opa_d     = quo_nxt;
                    rem_d     = rem_nxt;
                    cnt_d     = cnt_q + 5'd1;
                    if (cnt_q == CNT_LAST) begin
                        lo_d    = quo_fix;
                        hi_d    = rem_fix;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus.busy = (state_q != S_IDLE);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for the multiply/divide HI/LO controller.
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   n;

    muldiv_hilo_ctrl_if bus ();

    muldiv_hilo_ctrl #(.DIV_CYCLES(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an instruction, count stalled cycles, release in DONE, return to IDLE.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        bus.en     = 1'b1;
        bus.funct  = f;
        bus.rs_val = a;
        bus.rt_val = b;
        cycles     = 0;
        #1;
        while (bus.stall && cycles < 100) begin
            cycles++;
            step();
        end
        bus.en    = 1'b0;
        bus.funct = 6'd0;
        step();
    endtask

    task automatic move_to(input logic [5:0] f, input logic [31:0] a);
        bus.en     = 1'b1;
        bus.funct  = f;
        bus.rs_val = a;
        #1;
        chk("mtx_no_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.en    = 1'b0;
        bus.funct = 6'd0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        bus.en     = 1'b0;
        bus.funct  = 6'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.cancel = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();

        chk("rst_hi",    bus.hi, 32'd0);
        chk("rst_lo",    bus.lo, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);

        // Back-to-back mthi / mtlo
        bus.en     = 1'b1;
        bus.funct  = F_MTHI;
        bus.rs_val = 32'h1234;
        #1;
        chk("mthi_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.funct  = F_MTLO;
        bus.rs_val = 32'h5678;
        #1;
        chk("mtlo_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.en    = 1'b0;
        bus.funct = 6'd0;
        chk("mthi_hi", bus.hi, 32'h1234);
        chk("mtlo_lo", bus.lo, 32'h5678);

        // mthi suppressed by cancel
        bus.en     = 1'b1;
        bus.funct  = F_MTHI;
        bus.rs_val = 32'hDEAD;
        bus.cancel = 1'b1;
        step();
        bus.en     = 1'b0;
        bus.cancel = 1'b0;
        chk("mthi_cancel_hi", bus.hi, 32'h1234);

        // Signed and unsigned multiply
        run_op(F_MULT, 32'd7, 32'hFFFF_FFFD, n);
        chk("mult_stall", 32'(n), 32'd2);
        chk("mult_hi",    bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo",    bus.lo, 32'hFFFF_FFEB);
        chk("mult_busy",  {31'd0, bus.busy}, 32'd0);
        run_op(F_MULTU, 32'd7, 32'hFFFF_FFFD, n);
        chk("multu_stall", 32'(n), 32'd2);
        chk("multu_hi",    bus.hi, 32'h0000_0006);
        chk("multu_lo",    bus.lo, 32'hFFFF_FFEB);

        // Divides
        run_op(F_DIVU, 32'd100, 32'd7, n);
        chk("divu_stall", 32'(n), 32'd33);
        chk("divu_lo",    bus.lo, 32'd14);
        chk("divu_hi",    bus.hi, 32'd2);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_neg_stall", 32'(n), 32'd33);
        chk("div_neg_lo",    bus.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi",    bus.hi, 32'hFFFF_FFFF);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0000_0000);

        // Divide by zero keeps HI/LO
        move_to(F_MTHI, 32'h11);
        move_to(F_MTLO, 32'h22);
        run_op(F_DIV, 32'd50, 32'd0, n);
        chk("div0_stall", 32'(n), 32'd2);
        chk("div0_hi",    bus.hi, 32'h11);
        chk("div0_lo",    bus.lo, 32'h22);

        // Cancel at DIV counter 5
        move_to(F_MTHI, 32'hA);
        move_to(F_MTLO, 32'hB);
        bus.en     = 1'b1;
        bus.funct  = F_DIVU;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        step();
        repeat (5) step();
        chk("cancel_pre_busy", {31'd0, bus.busy}, 32'd1);
        bus.cancel = 1'b1;
        #1;
        chk("cancel_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.cancel = 1'b0;
        bus.en     = 1'b0;
        bus.funct  = 6'd0;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        chk("cancel_hi",   bus.hi, 32'hA);
        chk("cancel_lo",   bus.lo, 32'hB);
        run_op(F_DIVU, 32'd9, 32'd3, n);
        chk("post_cancel_lo", bus.lo, 32'd3);
        chk("post_cancel_hi", bus.hi, 32'd0);

        // Reset at DIV counter 10
        move_to(F_MTHI, 32'h55);
        move_to(F_MTLO, 32'h66);
        bus.en     = 1'b1;
        bus.funct  = F_DIVU;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        step();
        repeat (10) step();
        chk("rst_mid_busy",  {31'd0, bus.busy},  32'd1);
        chk("rst_mid_stall", {31'd0, bus.stall}, 32'd1);
        resetn = 1'b0;
        bus.en = 1'b0;
        step();
        resetn = 1'b1;
        chk("rst_mid_busy_after",  {31'd0, bus.busy},  32'd0);
        chk("rst_mid_stall_after", {31'd0, bus.stall}, 32'd0);
        chk("rst_mid_hi",          bus.hi, 32'd0);
        chk("rst_mid_lo",          bus.lo, 32'd0);
        step();
        chk("rst_mid_idle", {31'd0, bus.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
